// File: rtl/joystick_sampler.sv
// Joystick sampling front end: periodic ADC requests, box-car averaging,
// center offset removal, deadzone direction decode.
module joystick_sampler #(
  parameter int SAMPLE_PERIOD = 50000,
  parameter int AVG_LOG2      = 2,
  parameter int CENTER        = 512,
  parameter int DEADZONE      = 64,
  parameter int TIMEOUT       = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  output logic        adc_start,
  input  logic [9:0]  x_in,
  input  logic [9:0]  y_in,
  input  logic        in_valid,
  output logic [9:0]  x_avg,
  output logic [9:0]  y_avg,
  output logic [10:0] x_off,
  output logic [10:0] y_off,
  output logic [3:0]  dir,
  output logic        out_valid,
  output logic        timeout_err,
  output logic        overrun
);

  localparam int PCNT_W = $clog2(SAMPLE_PERIOD);
  localparam int TOUT_W = $clog2(TIMEOUT + 1);
  localparam int ACC_W  = 10 + AVG_LOG2;
  localparam int CNT_W  = AVG_LOG2 + 1;

  localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(SAMPLE_PERIOD - 1);
  localparam logic [TOUT_W-1:0] TOUT_LAST = TOUT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'((1 << AVG_LOG2) - 1);
  localparam logic signed [10:0] CENTER_S = 11'(CENTER);
  localparam logic signed [10:0] DZ_POS   = 11'(DEADZONE);
  localparam logic signed [10:0] DZ_NEG   = 11'(-DEADZONE);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_BUSY = 2'd2;
  localparam logic [1:0] ST_CALC = 2'd3;

  logic [1:0]        state_reg;
  logic [PCNT_W-1:0] pcnt_reg;
  logic [TOUT_W-1:0] tout_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic              calc_phase_reg;
  logic              out_valid_reg;
  logic [3:0]        dir_reg;

  logic tick;
  logic accept;
  logic calc_load;
  logic win_clear;

  // The tick is the wrap cycle of the period counter; it is never deferred.
  assign tick        = enable && (state_reg != ST_IDLE) && (pcnt_reg == PCNT_LAST);
  assign adc_start   = tick && (state_reg == ST_WAIT);
  assign overrun     = tick && ((state_reg == ST_BUSY) || (state_reg == ST_CALC));
  assign accept      = enable && (state_reg == ST_BUSY) && in_valid;
  assign timeout_err = enable && (state_reg == ST_BUSY) && !in_valid && (tout_reg == TOUT_LAST);
  assign calc_load   = enable && (state_reg == ST_CALC) && !calc_phase_reg;
  assign win_clear   = !enable || ((state_reg == ST_CALC) && calc_phase_reg);

  logic [9:0] samp [2];
  assign samp[0] = x_in;
  assign samp[1] = y_in;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_axis
      logic [ACC_W-1:0]   acc_reg;
      logic [9:0]         avg_reg;
      logic [10:0]        off_reg;
      logic [9:0]         avg_w;
      logic signed [10:0] off_w;
      logic               pos_w;
      logic               neg_w;

      assign avg_w = 10'(acc_reg >> AVG_LOG2);
      assign off_w = $signed({1'b0, avg_w}) - CENTER_S;
      assign pos_w = off_w > DZ_POS;
      assign neg_w = off_w < DZ_NEG;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          acc_reg <= '0;
          avg_reg <= '0;
          off_reg <= '0;
        end else begin
          if (win_clear) begin
            acc_reg <= '0;
          end else if (accept) begin
            acc_reg <= acc_reg + ACC_W'(samp[gi]);
          end
          if (calc_load) begin
            avg_reg <= avg_w;
            off_reg <= off_w;
          end
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= ST_IDLE;
      pcnt_reg       <= '0;
      tout_reg       <= '0;
      cnt_reg        <= '0;
      calc_phase_reg <= 1'b0;
      out_valid_reg  <= 1'b0;
      dir_reg        <= '0;
    end else begin
      out_valid_reg <= calc_load;
      if (calc_load) begin
        dir_reg <= {g_axis[1].pos_w, g_axis[1].neg_w, g_axis[0].neg_w, g_axis[0].pos_w};
      end
      if (!enable) begin
        state_reg      <= ST_IDLE;
        pcnt_reg       <= '0;
        tout_reg       <= '0;
        cnt_reg        <= '0;
        calc_phase_reg <= 1'b0;
      end else begin
        pcnt_reg <= (pcnt_reg == PCNT_LAST) ? '0 : pcnt_reg + 1'b1;
        case (state_reg)
          ST_IDLE: state_reg <= ST_WAIT;
          ST_WAIT: begin
            if (tick) begin
              state_reg <= ST_BUSY;
              tout_reg  <= TOUT_W'(1);
            end
          end
          ST_BUSY: begin
            // A result landing on the timeout cycle still wins.
            if (in_valid) begin
              cnt_reg        <= cnt_reg + 1'b1;
              calc_phase_reg <= 1'b0;
              state_reg      <= (cnt_reg == CNT_LAST) ? ST_CALC : ST_WAIT;
            end else if (tout_reg == TOUT_LAST) begin
              state_reg <= ST_WAIT;
            end else begin
              tout_reg <= tout_reg + 1'b1;
            end
          end
          ST_CALC: begin
            if (!calc_phase_reg) begin
              calc_phase_reg <= 1'b1;
            end else begin
              calc_phase_reg <= 1'b0;
              cnt_reg        <= '0;
              state_reg      <= ST_WAIT;
            end
          end
          default: state_reg <= ST_IDLE;
        endcase
      end
    end
  end

  assign x_avg     = g_axis[0].avg_reg;
  assign y_avg     = g_axis[1].avg_reg;
  assign x_off     = g_axis[0].off_reg;
  assign y_off     = g_axis[1].off_reg;
  assign dir       = dir_reg;
  assign out_valid = out_valid_reg;

endmodule

// File: tb/tb_joystick_sampler.sv
// Randomized bench for joystick_sampler against an event-time reference model
// built from sample windows and absolute tick/deadline cycle numbers.
module tb_joystick_sampler;

  localparam int P      = 100;
  localparam int L      = 2;
  localparam int NS     = 1 << L;
  localparam int CENTER = 512;
  localparam int DZ     = 64;
  localparam int TO     = 255;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        adc_start;
  logic [9:0]  x_in;
  logic [9:0]  y_in;
  logic        in_valid;
  logic [9:0]  x_avg;
  logic [9:0]  y_avg;
  logic [10:0] x_off;
  logic [10:0] y_off;
  logic [3:0]  dir;
  logic        out_valid;
  logic        timeout_err;
  logic        overrun;

  joystick_sampler #(
    .SAMPLE_PERIOD(P), .AVG_LOG2(L), .CENTER(CENTER), .DEADZONE(DZ), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .adc_start(adc_start),
    .x_in(x_in), .y_in(y_in), .in_valid(in_valid),
    .x_avg(x_avg), .y_avg(y_avg), .x_off(x_off), .y_off(y_off), .dir(dir),
    .out_valid(out_valid), .timeout_err(timeout_err), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // stimulus control
  logic rst_drv = 1'b1;
  logic en_drv  = 1'b0;
  bit   stray_en = 1'b0;
  int   cyc = 0;
  int   resp_at = -1;
  logic [9:0] resp_x, resp_y;
  int   plan_d[$];
  int   plan_x[$];
  int   plan_y[$];
  int   start_log[$];
  int   first_to = -1;
  int   win_count = 0;

  // reference model state
  bit   m_idle = 1'b1;
  bit   m_req = 1'b0;
  int   m_en_first = 0;
  int   m_req_start = 0;
  int   m_calc_end = -1;
  int   qx[$];
  int   qy[$];
  int   p_xa, p_ya;
  logic       e_ov = 1'b0;
  logic [9:0] e_xa = '0, e_ya = '0;
  logic [10:0] e_xo = '0, e_yo = '0;
  logic [3:0] e_dir = '0;

  function automatic int pick_code();
    int r;
    r = $urandom_range(0, 3);
    if (r == 0) return $urandom_range(0, 1023);
    if (r == 1) return CENTER + $urandom_range(0, 160) - 80;
    if (r == 2) return ($urandom_range(0, 1) == 1) ? 1023 : 0;
    return CENTER + (($urandom_range(0, 1) == 1) ? DZ : -DZ) + $urandom_range(0, 2) - 1;
  endfunction

  task automatic model_check();
    logic e_start, e_to, e_ovr, n_ov;
    bit tick, in_calc;
    int ox, oy;
    e_start = 0; e_to = 0; e_ovr = 0; n_ov = 0;
    if (rst) begin
      m_idle = 1; m_req = 0; m_calc_end = -1;
      qx.delete(); qy.delete();
      e_ov = 0; e_xa = '0; e_ya = '0; e_xo = '0; e_yo = '0; e_dir = '0;
    end else if (!enable) begin
      m_idle = 1; m_req = 0; m_calc_end = -1;
      qx.delete(); qy.delete();
    end else begin
      if (m_idle) begin
        m_idle = 0;
        m_en_first = cyc;
      end
      tick    = ((cyc - m_en_first) % P) == P - 1;
      in_calc = cyc <= m_calc_end;
      if (tick) begin
        if (m_req || in_calc) e_ovr = 1;
        else e_start = 1;
      end
      if (m_req) begin
        if (in_valid) begin
          qx.push_back(int'(x_in));
          qy.push_back(int'(y_in));
          m_req = 0;
          if (qx.size() == NS) begin
            p_xa = qx.sum() / NS;
            p_ya = qy.sum() / NS;
            qx.delete(); qy.delete();
            m_calc_end = cyc + 2;
          end
        end else if (cyc - m_req_start == TO) begin
          e_to = 1;
          m_req = 0;
        end
      end
      if (cyc == m_calc_end - 1) n_ov = 1;
      if (e_start) begin
        m_req = 1;
        m_req_start = cyc;
      end
    end
    check_eq("adc_start", adc_start, e_start);
    check_eq("timeout_err", timeout_err, e_to);
    check_eq("overrun", overrun, e_ovr);
    check_eq("out_valid", out_valid, e_ov);
    check_eq("x_avg", x_avg, e_xa);
    check_eq("y_avg", y_avg, e_ya);
    check_eq("x_off", x_off, e_xo);
    check_eq("y_off", y_off, e_yo);
    check_eq("dir", dir, e_dir);
    e_ov = n_ov;
    if (n_ov) begin
      ox = p_xa - CENTER;
      oy = p_ya - CENTER;
      e_xa  = 10'(p_xa);
      e_ya  = 10'(p_ya);
      e_xo  = 11'(ox);
      e_yo  = 11'(oy);
      e_dir = {oy > DZ, oy < -DZ, ox < -DZ, ox > DZ};
    end
  endtask

  task automatic schedule_resp();
    int d;
    if (plan_d.size() > 0) begin
      d = plan_d.pop_front();
      resp_x = 10'(plan_x.pop_front());
      resp_y = 10'(plan_y.pop_front());
    end else begin
      d = $urandom_range(0, 99);
      if (d < 8) d = -1;
      else if (d < 13) d = $urandom_range(100, 140);
      else d = $urandom_range(1, 90);
      resp_x = 10'(pick_code());
      resp_y = 10'(pick_code());
    end
    resp_at = (d < 0) ? -1 : cyc + d;
  endtask

  task automatic directed_window_checks(input int k);
    case (k)
      0: begin
        check_eq("w0_x_avg", x_avg, 512); check_eq("w0_y_avg", y_avg, 512);
        check_eq("w0_x_off", x_off, 0);   check_eq("w0_dir", dir, 4'b0000);
      end
      1: begin
        check_eq("w1_x_avg", x_avg, 1022); check_eq("w1_x_off", x_off, 510);
        check_eq("w1_y_avg", y_avg, 0);    check_eq("w1_y_off", y_off, 11'h600);
        check_eq("w1_dir", dir, 4'b0101);
      end
      2: check_eq("w2_dir_x576", dir, 4'b0000);
      3: check_eq("w3_dir_x577", dir, 4'b0001);
      4: begin
        check_eq("w4_x_off", x_off, 11'h7C0); check_eq("w4_dir_x448", dir, 4'b0000);
      end
      5: begin
        check_eq("w5_x_avg", x_avg, 250); check_eq("w5_y_avg", y_avg, 750);
      end
      default: ;
    endcase
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    rst    = rst_drv;
    enable = en_drv;
    in_valid = 1'b0;
    if (resp_at == cyc) begin
      in_valid = 1'b1;
      x_in = resp_x;
      y_in = resp_y;
    end else if (stray_en && resp_at < cyc && $urandom_range(0, 49) == 0) begin
      in_valid = 1'b1;
      x_in = 10'($urandom_range(0, 1023));
      y_in = 10'($urandom_range(0, 1023));
    end else begin
      x_in = 10'($urandom_range(0, 1023));
      y_in = 10'($urandom_range(0, 1023));
    end
    @(negedge clk);
    model_check();
    if (adc_start === 1'b1) begin
      start_log.push_back(cyc);
      schedule_resp();
    end
    if (timeout_err === 1'b1 && first_to < 0) first_to = cyc;
    if (out_valid === 1'b1) begin
      $display("cycle %0d window %0d: x_avg=%0d y_avg=%0d x_off=%0d y_off=%0d dir=%b",
               cyc, win_count, x_avg, y_avg, $signed(x_off), $signed(y_off), dir);
      directed_window_checks(win_count);
      win_count++;
    end
    cyc++;
  endtask

  task automatic run_windows(input int target, input int budget);
    for (int i = 0; i < budget && win_count < target; i++) step();
    check_eq("window_budget", win_count >= target, 1);
  endtask

  task automatic run_starts(input int n, input int budget);
    int goal;
    goal = start_log.size() + n;
    for (int i = 0; i < budget && start_log.size() < goal; i++) step();
    check_eq("start_budget", start_log.size() >= goal, 1);
  endtask

  task automatic add_plan(input int d, input int x, input int y);
    plan_d.push_back(d);
    plan_x.push_back(x);
    plan_y.push_back(y);
  endtask

  initial begin
    int first_en, re_en, w0, s_drop;
    rst = 1'b1; enable = 1'b0; in_valid = 1'b0; x_in = '0; y_in = '0;
    for (int i = 0; i < 3; i++) step();
    rst_drv = 1'b0;
    for (int i = 0; i < 3; i++) step();

    for (int i = 0; i < 4; i++) add_plan(5, 512, 512);
    add_plan(7, 1023, 0); add_plan(7, 1023, 0); add_plan(7, 1023, 0); add_plan(7, 1020, 3);
    for (int i = 0; i < 4; i++) add_plan(3, 576, 512);
    for (int i = 0; i < 4; i++) add_plan(3, 577, 512);
    for (int i = 0; i < 4; i++) add_plan(3, 448, 512);
    add_plan(-1, 0, 0);
    add_plan(4, 100, 900); add_plan(4, 200, 800); add_plan(4, 300, 700); add_plan(4, 400, 600);

    en_drv = 1'b1;
    first_en = cyc;
    run_windows(6, 4000);
    check_eq("starts_seen", start_log.size() >= 25, 1);
    check_eq("start0", start_log[0] - first_en, P - 1);
    check_eq("start1", start_log[1] - first_en, 2 * P - 1);
    check_eq("start2", start_log[2] - first_en, 3 * P - 1);
    check_eq("timeout_at", first_to - start_log[20], TO);

    stray_en = 1'b1;
    run_starts(100, 40000);

    stray_en = 1'b0;
    run_starts(1, 500);
    s_drop = start_log.size();
    add_plan(10, 1000, 20);
    run_starts(1, 500);
    for (int i = 0; i < 3; i++) step();
    w0 = win_count;
    en_drv = 1'b0;
    for (int i = 0; i < 25; i++) step();
    check_eq("no_out_when_idle", win_count, w0);
    en_drv = 1'b1;
    re_en = cyc;
    run_starts(1, 500);
    check_eq("restart_period", start_log[s_drop + 1] - re_en, P - 1);

    stray_en = 1'b1;
    run_starts(7, 3000);
    for (int i = 0; i < 20; i++) step();
    rst_drv = 1'b1;
    step();
    step();
    rst_drv = 1'b0;
    run_starts(30, 12000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
